// File: rtl/cpu_result_display.sv
// cpu_result_display: freezes the CPU result once it settles and scans it onto a 4-digit seven-segment display
module cpu_result_display #(
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic [15:0] result_reg,
  input  logic        run_start,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        done,
  output logic [15:0] shown_value,
  output logic [15:0] cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] prev, prev_n, stable_cnt, stable_n, shown_n, count_n, refresh_cnt;
  logic [1:0] digit_idx;
  logic [3:0] nib;
  // run-tracking state register
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      state       <= IDLE;
      prev        <= '0;
      stable_cnt  <= '0;
      shown_value <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      stable_cnt  <= stable_n;
      shown_value <= shown_n;
      cycle_count <= count_n;
    end
  end
  // next state: restart beats completion; the stability window restarts on every sampled change
  always_comb begin
    state_n  = state;
    prev_n   = prev;
    stable_n = stable_cnt;
    shown_n  = shown_value;
    count_n  = cycle_count;
    if (run_start) begin
      state_n  = RUN;
      prev_n   = result_reg;
      stable_n = '0;
      count_n  = '0;
      shown_n  = result_reg;
    end else if (state == IDLE) begin
      shown_n = result_reg;
    end else if (state == RUN) begin
      shown_n = result_reg;
      count_n = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
      if (result_reg != prev) begin
        prev_n   = result_reg;
        stable_n = '0;
      end else if (stable_cnt == 16'(STABLE_CYCLES - 1)) begin
        state_n = DONE;
      end else begin
        stable_n = stable_cnt + 16'd1;
      end
    end
  end
  // digit scan: each digit stays lit for REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == 16'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end
  assign done = (state == DONE);
  assign an   = ~(4'b0001 << digit_idx);
  assign nib  = shown_value[{digit_idx, 2'b00} +: 4];
  // active-low hex font for the selected nibble
  always_comb begin
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: tb/tb_cpu_result_display.sv
// tb_cpu_result_display: directed and randomized checks against a behavioural display model
module tb_cpu_result_display;
  localparam int RD = 4;
  localparam int SC = 4;
  logic clk = 0;
  logic pc_reset = 1;
  logic [15:0] result_reg = 16'hBEEF;
  logic run_start = 0;
  logic [6:0] seg;
  logic [3:0] an;
  logic done;
  logic [15:0] shown_value, cycle_count;
  int checks = 0, errors = 0;
  int edge_n = 0, scan_n = 0, win_start = 0, mode = 0;
  logic [15:0] m_shown = 0, m_count = 0, m_prev = 0;
  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  cpu_result_display #(.REFRESH_DIV(RD), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .pc_reset(pc_reset), .result_reg(result_reg), .run_start(run_start),
    .seg(seg), .an(an), .done(done), .shown_value(shown_value), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 run, 2 done; a run completes SC edges after its window opened
  task automatic step();
    edge_n++;
    if (pc_reset) begin
      mode = 0; m_shown = 0; m_count = 0; m_prev = 0; scan_n = 0;
    end else begin
      scan_n++;
      if (run_start) begin
        mode = 1; m_prev = result_reg; m_count = 0; m_shown = result_reg; win_start = edge_n;
      end else if (mode == 0) begin
        m_shown = result_reg;
      end else if (mode == 1) begin
        m_shown = result_reg;
        if (m_count != 16'hFFFF) m_count++;
        if (result_reg != m_prev) begin
          m_prev = result_reg; win_start = edge_n;
        end else if (edge_n - win_start == SC) mode = 2;
      end
    end
  endtask

  task automatic check_all();
    int d;
    logic [15:0] sh;
    d = (scan_n / RD) % 4;
    sh = m_shown >> (4 * d);
    check("an", an, 4'hF & ~(4'd1 << d));
    check("seg", seg, font[sh[3:0]]);
    check("done", done, mode == 2);
    check("shown", shown_value, m_shown);
    check("count", cycle_count, m_count);
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    #1;
    check_all();
  endtask

  initial begin
    tick(); tick();
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_done", done, 0);
    check("rst_shown", shown_value, 0);
    check("rst_count", cycle_count, 0);
    pc_reset = 0; result_reg = 16'h1234;
    tick();
    check("idle_shown", shown_value, 16'h1234);
    check("idle_seg", seg, 7'b0011001);
    repeat (4) tick();
    check("scan_an1", an, 4'b1101);
    check("scan_seg1", seg, 7'b0110000);
    repeat (12) tick();
    check("scan_wrap", an, 4'b1110);
    result_reg = 16'h00AF; run_start = 1;
    tick();
    run_start = 0;
    repeat (3) tick();
    check("const_early", done, 0);
    tick();
    check("const_done", done, 1);
    check("const_count", cycle_count, 4);
    check("const_shown", shown_value, 16'h00AF);
    result_reg = 16'h1111;
    repeat (3) tick();
    check("done_hold", shown_value, 16'h00AF);
    result_reg = 16'h0005; run_start = 1;
    tick();
    run_start = 0;
    tick();
    result_reg = 16'h0006;
    repeat (3) tick();
    result_reg = 16'h0007;
    repeat (4) tick();
    check("chg_early", done, 0);
    tick();
    check("chg_done", done, 1);
    check("chg_count", cycle_count, 9);
    check("chg_shown", shown_value, 16'h0007);
    run_start = 1;
    tick();
    run_start = 0;
    tick();
    pc_reset = 1;
    tick();
    pc_reset = 0;
    check("abort_count", cycle_count, 0);
    check("abort_an", an, 4'b1110);
    check("abort_done", done, 0);
    tick();
    run_start = 1;
    tick();
    run_start = 0;
    repeat (4) tick();
    check("pre_restart", done, 1);
    run_start = 1;
    tick();
    run_start = 0;
    check("restart_done", done, 0);
    check("restart_count", cycle_count, 0);
    tick();
    check("restart_count1", cycle_count, 1);
    repeat (3) tick();
    run_start = 1;
    tick();
    run_start = 0;
    check("tie_done", done, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) result_reg = 16'($urandom);
      run_start = ($urandom_range(19) == 0);
      pc_reset = ($urandom_range(79) == 0);
      tick();
    end
    pc_reset = 0; run_start = 1;
    tick();
    run_start = 0;
    for (int i = 0; i < 70000; i++) begin
      result_reg = ~result_reg;
      tick();
    end
    check("sat_count", cycle_count, 16'hFFFF);
    check("sat_done", done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
